shift_capture: RTL and testbench
================================

# shift_capture

Serial-to-parallel capture stage that sits directly downstream of `shift_ctrl`. It watches `shld` and `serclk`, the strobes `shift_ctrl` drives toward the external parallel-in/serial-out register, and samples the returning serial line `sdata` once per `serclk` rising edge. It assembles `WIDTH`-bit words MSB first and presents each completed word on a valid/ready output port. Sticky flags report overruns and malformed frames.

## Interface
- `WIDTH`, default 8: bits per frame; must be ≥ 2.
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset; block is held in reset while 0.
- `shld`  in  1  from `shift_ctrl`; 0 = load phase / frame boundary, 1 = shift phase.
- `serclk`  in  1  from `shift_ctrl`; registered serial clock, same `clk` domain.
- `done`  in  1  from `shift_ctrl`; frame-end indication.
- `sdata`  in  1  serial data returned by the external register.
- `err_clr`  in  1  one-cycle pulse; clears `overrun` and `frame_err`.
- `data_out`  out  WIDTH  captured word, MSB = first bit received.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `data_ready`  in  1  consumer accepts the word on `data_valid && data_ready`.
- `overrun`  out  1  sticky: a completed word was dropped.
- `frame_err`  out  1  sticky: a short frame, or extra bits after a full frame.
- `busy`  out  1  state is SHIFT.

## Operation
- Edge detect: `serclk_q` register. `rise = serclk && !serclk_q`. `serclk_q` resets to 0.
- Bit counter `bitcnt`, width `$clog2(WIDTH+1)`, range 0..WIDTH, never wraps.
- Shift register `sr[WIDTH-1:0]`. On capture, `sr <= {sr[WIDTH-2:0], sdata}`.
- FSM states:
  - IDLE: while `shld==0`, hold `bitcnt=0`. Go to SHIFT when `shld==1`.
  - SHIFT: on `rise && shld && !done`, capture and increment `bitcnt`.
    - On the capture that makes `bitcnt==WIDTH`, do the word hand-off and go to HOLD.
    - On `done==1` with `bitcnt<WIDTH`, set `frame_err`, discard the partial word and go to HOLD.
  - HOLD: ignore `sdata`. Any `rise && shld` here sets `frame_err`. Go to IDLE on `shld==0`.
- `shld==0` in any state forces IDLE and `bitcnt=0` on the next edge. This abort takes priority over a same-cycle `rise`; no capture occurs.
- Hand-off, on the edge that completes a word:
  - If `!data_valid`, or `data_valid && data_ready` in the same cycle: `data_out <= {sr[WIDTH-2:0], sdata}` and `data_valid <= 1`.
  - Otherwise: the new word is dropped, the old `data_out` is kept, and `overrun <= 1`.
- `data_valid` clears on `data_valid && data_ready` when no new word completes that cycle.
- Sticky flags: `err_clr` clears both flags. If a set condition coincides with `err_clr`, set wins.

## Timing
- Every register resets asynchronously to 0: `data_out`, `data_valid`, `overrun`, `frame_err`, `busy`, `bitcnt`, `sr`, `serclk_q`; FSM to IDLE.
- Capture is on the `clk` edge at which `rise` is observed. Latency from the last capture edge to `data_valid=1` is 0 cycles (same edge).
- With `shift_ctrl` at its own default `WIDTH=8`: `serclk` rises 8 times per frame (16 toggles), giving exactly one full frame per `shld` assertion.
- `data_valid` may stay high indefinitely; `data_out` is stable while `data_valid && !data_ready`.
- Reset asserted mid-frame: all state clears immediately. The first post-reset frame begins only after `shld` is observed 0.
- `busy` is registered and equals (state==SHIFT).

## Structure
- No shared-package typedefs are needed. FSM encoding (IDLE/SHIFT/HOLD) is local.
- `WIDTH` is a per-instance parameter. It must match the frame length the instantiating level configures in `shift_ctrl`.
- One natural sub-module, `shift_edge_det`, holds `serclk_q` and the `rise` output. The FSM, shifter and output register stay in `shift_capture`.
- Expected size is about 150–250 lines.

## Test plan
- Nominal frame: drive a `shift_ctrl` model with `sdata` bits 1,0,1,1,0,0,1,0 and `data_ready=1`. Expect `data_out=8'hB2` and a one-cycle `data_valid` on the 8th rise edge; flags stay 0.
- Back-pressure: two frames `8'hA5` then `8'h3C` with `data_ready=0`. Expect `data_out` to hold `8'hA5`, `overrun=1`; `data_ready=1` then consumes `8'hA5` and `data_valid` drops.
- Simultaneous accept: the second word completes on the same cycle as `data_valid && data_ready`. Expect `data_out=8'h3C`, `data_valid` stays 1, `overrun=0`.
- Short frame: assert `done` after 5 rises. Expect `frame_err=1`, no `data_valid`; `err_clr` then returns `frame_err` to 0.
- Abort: drop `shld` after 3 rises, then run a clean frame `8'h81`. Expect `data_out=8'h81` and no error.
- Async reset: pull `reset` low after 4 rises. Expect all outputs 0 immediately; the next full frame `8'hFF` is captured correctly.

Source files
------------

// File: rtl/shift_capture_pkg.sv
// rtl/shift_capture_pkg.sv - FSM encoding shared by the shift_capture slice
package shift_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/shift_edge_det.sv
// rtl/shift_edge_det.sv - registered rising-edge detector for serclk
module shift_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic serclk,
  output logic rise
);

  logic serclk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serclk_q <= 1'b0;
    end else begin
      serclk_q <= serclk;
    end
  end

  assign rise = serclk && !serclk_q;

endmodule

// File: rtl/shift_capture.sv
// rtl/shift_capture.sv - serial-to-parallel capture behind shift_ctrl, MSB first
module shift_capture
  import shift_capture_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shld,
  input  logic             serclk,
  input  logic             done,
  input  logic             sdata,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  cap_state_t       state;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] sr;
  logic             armed;
  logic             rise;
  logic             sr_msb_unused;

  assign sr_msb_unused = sr[WIDTH-1];

  shift_edge_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .serclk (serclk),
    .rise   (rise)
  );

  // armed stays low after reset until shld is seen low, so a frame already in
  // flight when reset releases is never captured as if it were a fresh one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bitcnt     <= '0;
      sr         <= '0;
      armed      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (err_clr) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (!shld) begin
        armed  <= 1'b1;
        state  <= ST_IDLE;
        busy   <= 1'b0;
        bitcnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (armed) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (done) begin
              frame_err <= 1'b1;
              state     <= ST_HOLD;
              busy      <= 1'b0;
            end else if (rise) begin
              sr     <= {sr[WIDTH-2:0], sdata};
              bitcnt <= bitcnt + CW'(1);
              if (bitcnt == LAST) begin
                state <= ST_HOLD;
                busy  <= 1'b0;
                if (!data_valid || data_ready) begin
                  data_out   <= {sr[WIDTH-2:0], sdata};
                  data_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end
          end
          ST_HOLD: begin
            if (rise) begin
              frame_err <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_capture.sv
// tb/tb_shift_capture.sv - directed table-driven bench for shift_capture
module tb_shift_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       shld = 1'b0;
  logic       serclk = 1'b0;
  logic       done = 1'b0;
  logic       sdata = 1'b0;
  logic       err_clr = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  shift_capture #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .shld       (shld),
    .serclk     (serclk),
    .done       (done),
    .sdata      (sdata),
    .err_clr    (err_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;
    logic       ready;
    logic [7:0] exp_data;
    logic       exp_overrun;
    logic       exp_valid_after;
    logic       clr_after;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_frame();
    shld = 1'b0;
    tick();
    shld = 1'b1;
    tick();
  endtask

  task automatic pulse_bit(input logic b);
    sdata  = b;
    serclk = 1'b1;
    tick();
  endtask

  task automatic serclk_low();
    serclk = 1'b0;
    tick();
  endtask

  // leaves serclk high right after the n-th rise so the caller can sample
  task automatic shift_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      pulse_bit(w[7-i]);
      if (i < n - 1) serclk_low();
    end
  endtask

  task automatic end_frame();
    done = 1'b1;
    tick();
    done = 1'b0;
    shld = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hB2, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h81, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0};

    tick();
    tick();
    check("reset data_out", data_out, 8'h00);
    check("reset data_valid", data_valid, 1'b0);
    check("reset overrun", overrun, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      data_ready = vecs[v].ready;
      start_frame();
      check($sformatf("vec%0d busy in frame", v), busy, 1'b1);
      shift_bits(vecs[v].bits, 8);
      check($sformatf("vec%0d data_out", v), data_out, vecs[v].exp_data);
      check($sformatf("vec%0d data_valid", v), data_valid, 1'b1);
      check($sformatf("vec%0d overrun", v), overrun, vecs[v].exp_overrun);
      check($sformatf("vec%0d frame_err", v), frame_err, 1'b0);
      check($sformatf("vec%0d busy in hold", v), busy, 1'b0);
      serclk_low();
      check($sformatf("vec%0d valid after", v), data_valid, vecs[v].exp_valid_after);
      end_frame();
      if (vecs[v].clr_after) begin
        pulse_clr();
        check($sformatf("vec%0d overrun cleared", v), overrun, 1'b0);
      end
    end

    // back-pressure: second word dropped, first word held until consumed
    data_ready = 1'b0;
    start_frame();
    shift_bits(8'hA5, 8);
    serclk_low();
    end_frame();
    start_frame();
    shift_bits(8'h3C, 8);
    check("bp data held", data_out, 8'hA5);
    check("bp valid held", data_valid, 1'b1);
    check("bp overrun", overrun, 1'b1);
    serclk_low();
    end_frame();
    data_ready = 1'b1;
    tick();
    check("bp consumed valid", data_valid, 1'b0);
    check("bp overrun sticky", overrun, 1'b1);
    pulse_clr();
    check("bp overrun cleared", overrun, 1'b0);

    // simultaneous accept on the completing edge
    data_ready = 1'b0;
    start_frame();
    shift_bits(8'hA5, 8);
    serclk_low();
    end_frame();
    start_frame();
    shift_bits(8'h3C, 7);
    serclk_low();
    data_ready = 1'b1;
    pulse_bit(1'b0);
    check("simul data_out", data_out, 8'h3C);
    check("simul data_valid", data_valid, 1'b1);
    check("simul overrun", overrun, 1'b0);
    serclk_low();
    check("simul consumed", data_valid, 1'b0);
    end_frame();

    // short frame
    start_frame();
    shift_bits(8'hF0, 5);
    serclk_low();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("short frame_err", frame_err, 1'b1);
    check("short no valid", data_valid, 1'b0);
    check("short busy", busy, 1'b0);
    shld = 1'b0;
    tick();
    pulse_clr();
    check("short cleared", frame_err, 1'b0);

    // extra bit after a full frame, then err_clr racing a new set
    start_frame();
    shift_bits(8'h96, 8);
    serclk_low();
    pulse_bit(1'b1);
    check("extra frame_err", frame_err, 1'b1);
    check("extra data kept", data_out, 8'h96);
    serclk_low();
    err_clr = 1'b1;
    pulse_bit(1'b0);
    err_clr = 1'b0;
    check("clr vs set", frame_err, 1'b1);
    serclk_low();
    end_frame();
    pulse_clr();
    check("extra cleared", frame_err, 1'b0);

    // abort mid-frame then clean frame
    start_frame();
    shift_bits(8'hE0, 3);
    serclk_low();
    shld = 1'b0;
    tick();
    check("abort busy", busy, 1'b0);
    start_frame();
    shift_bits(8'h81, 8);
    check("abort next data", data_out, 8'h81);
    check("abort next valid", data_valid, 1'b1);
    check("abort no err", frame_err, 1'b0);
    serclk_low();
    end_frame();

    // async reset mid-frame with state loaded
    data_ready = 1'b0;
    start_frame();
    shift_bits(8'h5A, 8);
    serclk_low();
    pulse_bit(1'b1);
    serclk_low();
    end_frame();
    start_frame();
    shift_bits(8'hC3, 4);
    check("pre-reset busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("areset data_out", data_out, 8'h00);
    check("areset data_valid", data_valid, 1'b0);
    check("areset frame_err", frame_err, 1'b0);
    check("areset busy", busy, 1'b0);
    serclk = 1'b0;
    tick();
    reset = 1'b1;
    data_ready = 1'b1;
    tick();
    shift_bits(8'hAA, 8);
    check("post-reset no capture", data_valid, 1'b0);
    check("post-reset idle", busy, 1'b0);
    serclk_low();
    end_frame();
    start_frame();
    shift_bits(8'hFF, 8);
    check("post-reset data", data_out, 8'hFF);
    check("post-reset valid", data_valid, 1'b1);
    serclk_low();
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
